// File: rtl/arb_pkg.sv
// Shared types for the operand arbiter: FSM states and pointer type.
// Default requester count sizes the round-robin pointer.
package arb_pkg;

    localparam int ARB_N_REQ = 4;

    typedef logic [$clog2(ARB_N_REQ)-1:0] ptr_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ERR,
        RESP
    } state_t;

endpackage

// File: rtl/op_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr,
// found by masking a doubled request vector and isolating its lowest bit.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 any_req
);

    localparam logic [2*N-1:0] ONE = (2*N)'(1);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] below;
    logic [2*N-1:0] masked;
    logic [2*N-1:0] first;

    always_comb begin
        dbl    = {req, req};
        below  = (ONE << ptr) - ONE;
        masked = dbl & ~below;
        // lowest set bit; the upper copy supplies the wrap-around
        first  = masked & ~(masked - ONE);
        gnt    = first[N-1:0] | first[2*N-1:N];
        any_req = |req;
    end

endmodule

// File: rtl/op_arbiter.sv
// Round-robin arbiter sharing one A+B datapath between N_REQ requesters,
// with operand range check, issue handshake and response timeout.
module op_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ       = ARB_N_REQ,
    parameter int W           = 4,
    parameter int MAX_OPERAND = 9,
    parameter int TIMEOUT     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               dp_valid,
    output logic [W-1:0]       dp_a,
    output logic [W-1:0]       dp_b,
    input  logic               dp_ready,
    input  logic               dp_rsp_valid,
    input  logic [W:0]         dp_rsp_sum,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W:0]         rsp_sum,
    output logic               rsp_err
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  MAX_V    = W'(MAX_OPERAND);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

    state_t             state;
    state_t             nstate;
    logic [PW-1:0]      ptr;
    logic [N_REQ-1:0]   gnt_q;
    logic [PW-1:0]      gnt_idx;
    logic [CW-1:0]      cnt;
    logic [N_REQ-1:0]   pick_gnt;
    logic               any_req;
    logic [W-1:0]       sel_a;
    logic [W-1:0]       sel_b;
    logic               bad;
    logic               timed_out;

    rr_pick #(.N(N_REQ)) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .any_req (any_req)
    );

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
            if (gnt_q[i]) gnt_idx = PW'(i);
        end
        bad       = (sel_a > MAX_V) || (sel_b > MAX_V);
        timed_out = (cnt == CNT_LAST);
    end

    always_comb begin
        nstate    = state;
        req_ready = '0;
        dp_valid  = 1'b0;
        rsp_valid = '0;
        unique case (state)
            IDLE: begin
                req_ready = pick_gnt;
                if (any_req) nstate = bad ? ERR : ISSUE;
            end
            ISSUE: begin
                dp_valid = 1'b1;
                if (dp_ready) nstate = WAIT;
            end
            WAIT: begin
                if (dp_rsp_valid || timed_out) nstate = RESP;
            end
            ERR: nstate = RESP;
            RESP: begin
                rsp_valid = gnt_q;
                nstate    = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            gnt_q   <= '0;
            dp_a    <= '0;
            dp_b    <= '0;
            cnt     <= '0;
            rsp_sum <= '0;
            rsp_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_q <= pick_gnt;
                        dp_a  <= sel_a;
                        dp_b  <= sel_b;
                    end
                end
                ISSUE: begin
                    if (dp_ready) cnt <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // a response in the last timeout cycle still wins
                    if (dp_rsp_valid) begin
                        rsp_sum <= dp_rsp_sum;
                        rsp_err <= 1'b0;
                    end else if (timed_out) begin
                        rsp_sum <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                ERR: begin
                    rsp_sum <= '0;
                    rsp_err <= 1'b1;
                end
                RESP: begin
                    ptr <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
